// File: rtl/scan_mux_pkg.sv
// Shared encodings and helpers for the scanning N-channel mux.
package scan_mux_pkg;

    localparam logic MODE_MAN  = 1'b0;
    localparam logic MODE_SCAN = 1'b1;

    typedef enum logic {
        ST_MAN  = 1'b0,
        ST_SCAN = 1'b1
    } sel_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/scan_mux_n_if.sv
// Source/consumer bundle of the scanning mux; master drives sources and ready.
interface scan_mux_n_if #(
    parameter int WIDTH = 8,
    parameter int CH    = 4
);
    import scan_mux_pkg::*;
    localparam int SEL_W = clog2(CH);

    logic                 mode;
    logic [SEL_W-1:0]     sel_in;
    logic                 sel_load;
    logic [CH*WIDTH-1:0]  din;
    logic [CH-1:0]        din_valid;
    logic [WIDTH-1:0]     dout;
    logic [SEL_W-1:0]     dout_ch;
    logic                 dout_valid;
    logic                 dout_ready;
    logic                 sel_err;

    modport master (
        output mode, sel_in, sel_load, din, din_valid, dout_ready,
        input  dout, dout_ch, dout_valid, sel_err
    );

    modport slave (
        input  mode, sel_in, sel_load, din, din_valid, dout_ready,
        output dout, dout_ch, dout_valid, sel_err
    );

endinterface

// File: rtl/scan_mux_sel_ctrl.sv
// Channel-select state machine: manual load-on-strobe or timed scan rotation.
module scan_mux_sel_ctrl
    import scan_mux_pkg::*;
#(
    parameter  int CH    = 4,
    parameter  int DWELL = 4,
    localparam int SEL_W = clog2(CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode_i,
    input  logic [SEL_W-1:0] sel_in_i,
    input  logic             sel_load_i,
    input  logic             stall_i,
    output logic [SEL_W-1:0] cur_sel_o,
    output logic             sel_err_o
);

    localparam int CNT_W = (DWELL > 1) ? clog2(DWELL) : 1;

    sel_state_e       state_q;
    logic [SEL_W-1:0] sel_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_cur;
    logic             err_q;
    logic             sel_ok;

    assign sel_ok  = 32'(sel_in_i) < CH;
    // Entering scan starts the current channel's slot from a fresh count.
    assign cnt_cur = (state_q == ST_MAN) ? '0 : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_MAN;
            sel_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= (mode_i == MODE_SCAN) ? ST_SCAN : ST_MAN;
            err_q   <= (mode_i == MODE_MAN) && sel_load_i && !sel_ok;
            if (mode_i == MODE_MAN) begin
                if (sel_load_i && sel_ok) sel_q <= sel_in_i;
            end else if (stall_i) begin
                cnt_q <= cnt_cur;
            end else if (cnt_cur == CNT_W'(DWELL - 1)) begin
                cnt_q <= '0;
                sel_q <= (sel_q == SEL_W'(CH - 1)) ? '0 : sel_q + SEL_W'(1);
            end else begin
                cnt_q <= cnt_cur + CNT_W'(1);
            end
        end
    end

    assign cur_sel_o = sel_q;
    assign sel_err_o = err_q;

endmodule

// File: rtl/scan_mux_n.sv
// Registered N-channel mux with manual/scan select and a valid/ready output stage.
module scan_mux_n
    import scan_mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CH    = 4,
    parameter int DWELL = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    scan_mux_n_if.slave bus
);

    localparam int SEL_W = clog2(CH);

    logic [CH-1:0][WIDTH-1:0] ch_data;
    logic [SEL_W-1:0]         cur_sel;
    logic                     stall;
    logic                     sel_err;
    logic [WIDTH-1:0]         dout_q;
    logic [SEL_W-1:0]         dout_ch_q;
    logic                     dout_valid_q;

    assign ch_data = bus.din;
    assign stall   = dout_valid_q && !bus.dout_ready;

    scan_mux_sel_ctrl #(.CH(CH), .DWELL(DWELL)) u_sel (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode_i     (bus.mode),
        .sel_in_i   (bus.sel_in),
        .sel_load_i (bus.sel_load),
        .stall_i    (stall),
        .cur_sel_o  (cur_sel),
        .sel_err_o  (sel_err)
    );

    // An unselected-invalid source simply loads a bubble (valid low).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q       <= '0;
            dout_ch_q    <= '0;
            dout_valid_q <= 1'b0;
        end else if (!stall) begin
            dout_q       <= ch_data[cur_sel];
            dout_ch_q    <= cur_sel;
            dout_valid_q <= bus.din_valid[cur_sel];
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_ch    = dout_ch_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.sel_err    = sel_err;

endmodule

// File: tb/tb_scan_mux_n.sv
// Bench for scan_mux_n: two instances (CH=4/DWELL=2, CH=3/DWELL=3) against a slot-arithmetic model.
module tb_scan_mux_n;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    scan_mux_n_if #(.WIDTH(8), .CH(4)) ia ();
    scan_mux_n_if #(.WIDTH(8), .CH(3)) ib ();

    scan_mux_n #(.WIDTH(8), .CH(4), .DWELL(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    scan_mux_n #(.WIDTH(8), .CH(3), .DWELL(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    int n_tests = 0;
    int n_fail  = 0;

    // Model: in scan, the channel is base + (accepted scan cycles since entry) / DWELL.
    int         NCH[2] = '{4, 3};
    int         NDW[2] = '{2, 3};
    int         m_sel[2], m_base[2], m_k[2], m_ch[2];
    bit         m_prev[2], m_vld[2], m_err[2];
    logic [7:0] m_dout[2];

    task automatic mreset();
        for (int d = 0; d < 2; d++) begin
            m_sel[d] = 0; m_base[d] = 0; m_k[d] = 0; m_ch[d] = 0;
            m_prev[d] = 0; m_vld[d] = 0; m_err[d] = 0; m_dout[d] = 8'h00;
        end
    endtask

    task automatic mstep(input int d, input logic mode, input logic load, input int si,
                         input logic rdy, input logic [31:0] din, input logic [3:0] dv);
        bit stall;
        stall = m_vld[d] && !rdy;
        if (!stall) begin
            m_dout[d] = din[m_sel[d]*8 +: 8];
            m_ch[d]   = m_sel[d];
            m_vld[d]  = dv[m_sel[d]];
        end
        m_err[d] = !mode && load && (si >= NCH[d]);
        if (!mode) begin
            if (load && si < NCH[d]) m_sel[d] = si;
        end else begin
            if (!m_prev[d]) begin
                m_base[d] = m_sel[d];
                m_k[d]    = 0;
            end
            if (!stall) m_k[d]++;
            m_sel[d] = (m_base[d] + m_k[d] / NDW[d]) % NCH[d];
        end
        m_prev[d] = mode;
    endtask

    function automatic logic [31:0] pack_a();
        return 32'({ia.sel_err, ia.dout_valid, 4'(ia.dout_ch), ia.dout});
    endfunction
    function automatic logic [31:0] pack_b();
        return 32'({ib.sel_err, ib.dout_valid, 4'(ib.dout_ch), ib.dout});
    endfunction
    function automatic logic [31:0] pack_m(input int d);
        return 32'({m_err[d], m_vld[d], 4'(m_ch[d]), m_dout[d]});
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        if (rst_n) begin
            mstep(0, ia.mode, ia.sel_load, int'(ia.sel_in), ia.dout_ready, ia.din, ia.din_valid);
            mstep(1, ib.mode, ib.sel_load, int'(ib.sel_in), ib.dout_ready, 32'(ib.din), 4'(ib.din_valid));
        end else begin
            mreset();
        end
        @(posedge clk);
        #1;
        chk("model_a", pack_a(), pack_m(0));
        chk("model_b", pack_b(), pack_m(1));
    endtask

    typedef struct {
        logic       mode;
        logic       load;
        logic [1:0] sel;
        logic       rdy;
        logic [3:0] dv;
        int         ch;
        logic       vld;
        logic [7:0] dout;
    } vec_t;
    vec_t tbl[19];

    function automatic vec_t v(input logic mode, input logic load, input logic [1:0] sel,
                               input logic rdy, input logic [3:0] dv, input int ch,
                               input logic vld, input logic [7:0] dout);
        vec_t r;
        r.mode = mode; r.load = load; r.sel = sel; r.rdy = rdy;
        r.dv = dv; r.ch = ch; r.vld = vld; r.dout = dout;
        return r;
    endfunction

    initial begin
        // Scan rotation, ignored load, 3-cycle stall, bubble on ch1, scan->manual->scan.
        tbl[0]  = v(1, 0, 0, 1, 4'hF, 0, 1, 8'h11);
        tbl[1]  = v(1, 0, 0, 1, 4'hF, 0, 1, 8'h11);
        tbl[2]  = v(1, 0, 0, 1, 4'hF, 1, 1, 8'h22);
        tbl[3]  = v(1, 1, 0, 1, 4'hF, 1, 1, 8'h22);
        tbl[4]  = v(1, 0, 0, 1, 4'hF, 2, 1, 8'h33);
        tbl[5]  = v(1, 0, 0, 1, 4'hF, 2, 1, 8'h33);
        tbl[6]  = v(1, 0, 0, 1, 4'hF, 3, 1, 8'h44);
        tbl[7]  = v(1, 0, 0, 1, 4'hF, 3, 1, 8'h44);
        tbl[8]  = v(1, 0, 0, 1, 4'hF, 0, 1, 8'h11);
        tbl[9]  = v(1, 0, 0, 0, 4'hF, 0, 1, 8'h11);
        tbl[10] = v(1, 0, 0, 0, 4'hF, 0, 1, 8'h11);
        tbl[11] = v(1, 0, 0, 0, 4'hF, 0, 1, 8'h11);
        tbl[12] = v(1, 0, 0, 1, 4'hF, 0, 1, 8'h11);
        tbl[13] = v(1, 0, 0, 1, 4'hD, 1, 0, 8'h22);
        tbl[14] = v(0, 0, 0, 1, 4'hD, 1, 0, 8'h22);
        tbl[15] = v(0, 0, 0, 1, 4'hD, 1, 0, 8'h22);
        tbl[16] = v(1, 0, 0, 1, 4'hD, 1, 0, 8'h22);
        tbl[17] = v(1, 0, 0, 1, 4'hD, 1, 0, 8'h22);
        tbl[18] = v(1, 0, 0, 1, 4'hD, 2, 1, 8'h33);

        ia.mode = 0; ia.sel_in = '0; ia.sel_load = 0; ia.din = '0; ia.din_valid = '0; ia.dout_ready = 1;
        ib.mode = 0; ib.sel_in = '0; ib.sel_load = 0; ib.din = '0; ib.din_valid = '0; ib.dout_ready = 1;
        mreset();

        // Power-on reset holds everything at zero.
        step();
        step();
        chk("por_a", pack_a(), 32'h0);
        chk("por_b", pack_b(), 32'h0);
        rst_n = 1'b1;

        // Randomized traffic on both instances against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) ia.mode = ~ia.mode;
            if ($urandom_range(0, 15) == 0) ib.mode = ~ib.mode;
            ia.sel_load   = ($urandom_range(0, 3) == 0);
            ib.sel_load   = ($urandom_range(0, 3) == 0);
            ia.sel_in     = 2'($urandom_range(0, 3));
            ib.sel_in     = 2'($urandom_range(0, 3));
            ia.dout_ready = ($urandom_range(0, 3) != 0);
            ib.dout_ready = ($urandom_range(0, 3) != 0);
            ia.din        = $urandom;
            ib.din        = 24'($urandom);
            ia.din_valid  = 4'($urandom | $urandom);
            ib.din_valid  = 3'($urandom | $urandom);
            step();
        end

        // Out-of-range select on the 3-channel instance.
        ia.sel_load = 0; ia.dout_ready = 1;
        ib.mode = 0; ib.dout_ready = 1; ib.din = 24'h332211; ib.din_valid = 3'h7;
        ib.sel_load = 1; ib.sel_in = 2'd1; step();
        ib.sel_load = 0; step();
        chk("oor_pre_ch", 32'(ib.dout_ch), 32'd1);
        chk("oor_pre_err", 32'(ib.sel_err), 32'd0);
        ib.sel_load = 1; ib.sel_in = 2'd3; step();
        chk("oor_err_on", 32'(ib.sel_err), 32'd1);
        chk("oor_ch_hold", 32'(ib.dout_ch), 32'd1);
        ib.sel_load = 0; step();
        chk("oor_err_off", 32'(ib.sel_err), 32'd0);
        step();
        chk("oor_ch_after", 32'(ib.dout_ch), 32'd1);
        chk("oor_dout_after", 32'(ib.dout), 32'h22);
        ib.mode = 1; ib.sel_load = 1; step();
        chk("scan_no_err", 32'(ib.sel_err), 32'd0);
        ib.sel_load = 0;

        // Reset arriving while a word is held by backpressure drops it.
        ia.mode = 0; ia.din = 32'h44332211; ia.din_valid = 4'hF; ia.dout_ready = 1;
        step();
        ia.dout_ready = 0;
        step();
        step();
        chk("stall_held_vld", 32'(ia.dout_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_a", pack_a(), 32'h0);
        chk("async_rst_b", pack_b(), 32'h0);
        step();
        step();
        rst_n = 1'b1;

        // Manual select after release: new channel shows one edge after the load edge.
        ia.dout_ready = 1; ia.mode = 0;
        step();
        ia.sel_load = 1; ia.sel_in = 2'd2;
        step();
        chk("man_load_edge_ch", 32'(ia.dout_ch), 32'd0);
        ia.sel_load = 0;
        step();
        chk("man_sel_dout", 32'(ia.dout), 32'h33);
        chk("man_sel_ch", 32'(ia.dout_ch), 32'd2);
        step();
        chk("man_sel_keep", 32'({ia.dout_valid, 4'(ia.dout_ch), ia.dout}), 32'h1233);

        // Directed scan table from a clean reset.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 19; i++) begin
            ia.mode = tbl[i].mode; ia.sel_load = tbl[i].load; ia.sel_in = tbl[i].sel;
            ia.dout_ready = tbl[i].rdy; ia.din_valid = tbl[i].dv;
            step();
            chk($sformatf("tbl[%0d]", i), pack_a() & 32'h1FFF,
                32'({tbl[i].vld, 4'(tbl[i].ch), tbl[i].dout}));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_mux_n.md
# scan_mux_n

Parametrised, registered N-channel, WIDTH-bit multiplexer: the next generation of the team's 4-to-1 mux. It adds a load-on-strobe manual channel select, an auto-scan mode that rotates through the channels with a programmable dwell, and a valid/ready output register with backpressure. It sits between a bank of parallel sources and a single downstream consumer, for example a shared serialiser or monitor port.

## Interface
Parameters:
- WIDTH, 8: data width per channel, ≥1.
- CH, 4: channel count, ≥2.
- DWELL, 4: cycles spent on each channel in scan mode, ≥1.
- SEL_W, derived as clog2(CH): select width (localparam, not overridable).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mode  in  1  0 = manual, 1 = scan; sampled every cycle.
- sel_in  in  SEL_W  manual channel index.
- sel_load  in  1  strobe; loads sel_in into the select register (manual mode only).
- din  in  CH*WIDTH  channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- din_valid  in  CH  per-channel valid.
- dout  out  WIDTH  registered selected data.
- dout_ch  out  SEL_W  channel index that produced dout.
- dout_valid  out  1  dout holds a valid word.
- dout_ready  in  1  consumer accepts the word when dout_valid && dout_ready.
- sel_err  out  1  one-cycle pulse: sel_load carried sel_in ≥ CH.

## Operation
**Select state machine** has two states, MAN and SCAN, and follows `mode`.
- Switching MAN→SCAN clears the dwell counter. Scan resumes from the current cur_sel.
- Switching SCAN→MAN keeps cur_sel.

**MAN state**
- A sel_load with sel_in < CH sets cur_sel ← sel_in at that edge.
- A sel_load with sel_in ≥ CH is ignored; sel_err pulses for 1 cycle.

**SCAN state**
- The dwell counter counts 0..DWELL-1.
- On reaching DWELL-1 with the pipe not stalled, cur_sel advances by 1 and the counter returns to 0.
- cur_sel wraps from CH-1 to 0.
- sel_load is ignored in SCAN: no update and no sel_err.

**Output register**
- Stall = dout_valid && !dout_ready.
- When not stalled, each edge captures:
  - dout ← din[cur_sel]
  - dout_ch ← cur_sel
  - dout_valid ← din_valid[cur_sel]
- When stalled:
  - dout, dout_ch and dout_valid hold.
  - The dwell counter and cur_sel freeze, so no scan slot is lost.
  - A sel_load in MAN still updates cur_sel.
- An invalid source (din_valid[cur_sel] = 0) loads dout_valid = 0. This is a bubble, not an error.

**Reset**
- Values while reset is asserted: cur_sel = 0, dwell = 0, dout = 0, dout_ch = 0, dout_valid = 0, sel_err = 0.
- The state machine enters MAN or SCAN according to mode on the first clock after release.
- Reset asserted mid-stall drops the held word.

## Timing
- Latency is 1 cycle from din/din_valid to dout/dout_valid.
- A sel_load at edge k changes cur_sel at edge k. Data from the new channel appears after edge k+1.
- Scan period is CH*DWELL unstalled cycles per full rotation. Each stall cycle extends the current slot by 1.
- sel_err asserts the cycle after the offending sel_load edge and lasts exactly 1 cycle.
- There are no combinational paths from inputs to outputs.

## Structure
- Package `scan_mux_pkg` holds:
  - mode encoding constants MODE_MAN = 1'b0 and MODE_SCAN = 1'b1.
  - state encoding for {MAN, SCAN}.
  - a clog2 function used to derive SEL_W.
- Sub-module `scan_mux_sel_ctrl` holds the select state machine, the dwell counter, cur_sel and sel_err. Its inputs are mode, sel_in, sel_load and stall; its output is cur_sel.
- The top level contains the channel-slice mux and the output register.

## Test plan
- **Reset and manual select.** Use WIDTH=8, CH=4. Assert rst_n=0 mid-run, then release; set din = {8'h44, 8'h33, 8'h22, 8'h11}, all valid, dout_ready=1, and pulse sel_load with sel_in=2.
  - While in reset, all outputs read 0.
  - After release and the sel_load, dout=8'h33 and dout_ch=2, two edges after the sel_load.
- **Out-of-range select.** Use CH=3. Hold cur_sel=1, then pulse sel_load with sel_in=3.
  - sel_err pulses for exactly 1 cycle.
  - cur_sel stays 1 and dout_ch stays 1.
- **Scan rotation.** Use DWELL=2, CH=4, mode=1, dout_ready=1.
  - dout_ch follows 0,0,1,1,2,2,3,3,0 with no gaps.
  - A sel_load during scan has no effect.
- **Backpressure.** In scan mode, drop dout_ready for 3 cycles mid-slot.
  - dout and dout_ch hold for those 3 cycles.
  - The slot still yields DWELL accepted words.
  - The rotation order is unchanged.
- **Bubble and mode switch.** Set din_valid[1]=0 while on channel 1, then toggle scan→manual→scan.
  - dout_valid=0 while channel 1 is selected.
  - The manual phase keeps the last cur_sel.
  - Scan restarts with a full DWELL on that channel.
